pipe_ctrl_bp: RTL and testbench
===============================

# pipe_ctrl_bp

Parametrised successor to the single-issue controller: decodes the D-stage instruction, carries control through its own D→E, E→M and M→W registers, resolves branches and jumps in E, and adds a direction predictor (table of 2-bit saturating counters) consulted in D. Sits between the instruction register and the datapath/hazard unit of the 5-stage RV32I core. It reuses maindec/aludec unchanged, so all ALUControl/ImmSrc/ResultSrc/ALUSrc encodings are the existing ones.

## Interface
Parameters:
- BHT_ENTRIES, 16: counter count; power of two, 2..256; index = pcD[log2(BHT_ENTRIES)+1:2].
- PRED_EN, 1: 1 = dynamic prediction; 0 = static not-taken (table held at reset value, jal still predicted).
- CTR_INIT, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- n_rst  in  1  reset, synchronous, active-high (asserted = 1 resets on the next rising edge).
- instrD  in  32  D-stage instruction.
- pcD  in  32  D-stage PC, predictor index source.
- nzcvE  in  4  E-stage ALU flags {N,Z,C,V} from rs1−rs2 (C = no borrow).
- flushE  in  1  hazard-unit bubble request for the D→E register.
- ImmSrcD  out  3  immediate select for D.
- predTakenD  out  1  D-stage redirect to branch/jal target.
- ALUControlE  out  5; ALUSrcAE  out  2; ALUSrcBE  out  1: E-stage ALU control.
- redirectE  out  1  E-stage misprediction/jalr redirect; hazard unit flushes D.
- PCSrcE  out  2  00 none, 01 E target (pcE+imm), 10 jalr target (ALU result), 11 pcE+4.
- MemWriteM  out  1; RegWriteM  out  1; ResultSrcM  out  2.
- RegWriteW  out  1; ResultSrcW  out  2.

## Operation
- Decode: combinational in D via maindec/aludec; branchD, jalD, jalrD from opcode.
- predTakenD = jalD | (branchD & PRED_EN & ctr[idxD][1]). Zero for non-branch/jal opcodes.
- D→E register captures control, funct3, predTakenD, idxD and validD=1. On flushE or redirectE it loads a bubble instead: RegWrite, MemWrite, branch, jal, jalr, valid = 0, other fields don't-care.
- E resolution (only if validE):
  - takenE from funct3E: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C; 010/011 not taken.
  - branchE & takenE & !predE → redirectE=1, PCSrcE=01.
  - branchE & !takenE & predE → redirectE=1, PCSrcE=11.
  - jalrE → redirectE=1, PCSrcE=10, every time.
  - jalE, correctly predicted branch, non-control instruction → redirectE=0, PCSrcE=00.
- Counter update: if validE & branchE & PRED_EN, ctr[idxE] increments (taken) or decrements (not taken), saturating at 00/11. One write per cycle.
- E→M and M→W registers always advance; no stall inputs.

## Timing
- Reset (n_rst=1 at edge): all E/M/W control outputs 0, validE=0, redirectE=0, PCSrcE=00; every counter = CTR_INIT in the same edge. predTakenD/ImmSrcD stay combinational from instrD.
- Latency: D decode → E outputs 1 cycle; M 2 cycles; W 3 cycles.
- Prediction read in D, counter written at end of E. Same-cycle read/write to the same index returns the old value; no bypass.
- redirectE is combinational from E state and nzcvE. It bubbles the instruction entering E on the same edge.
- flushE and redirectE together: one bubble, no other effect.
- Aliasing PCs share a counter; no tag check.
- Reset asserted mid-stream: in-flight instructions are discarded, the counter table reinitialises, and no counter update occurs on that edge.

## Test plan
- Reset: hold n_rst=1 for 2 cycles with random instrD → all E/M/W outputs 0, redirectE=0; counters read 01 (beq at pcD=0x40 gives predTakenD=0).
- Learning: beq at 0x40 with Z=1, executed three times → 1st: predTakenD=0, redirectE=1, PCSrcE=01, ctr 01→10; 2nd: predTakenD=1, redirectE=0, ctr→11; 3rd: ctr stays 11.
- Predicted-taken miss: ctr[0x40]=11, bne with Z=1 → redirectE=1, PCSrcE=11, ctr→10, and the next E is a bubble (RegWriteM=0 two cycles later).
- Jumps: jal → predTakenD=1, redirectE=0; jalr → redirectE=1, PCSrcE=10; counters unchanged.
- flushE on add x1 → RegWriteM=0 and RegWriteW=0 in the following cycles, no counter change; PRED_EN=0 build: beq taken 4× → predTakenD stays 0, redirectE=1 each time.
- Conflict and alias: E updates idx 3 while D reads idx 3 → old value seen; PCs 0x0C and 0x4C (16 entries) share a counter.

Source files
------------

// File: rtl/pipe_ctrl_bp.sv
// Pipelined RV32I controller: D-stage decode, D->E->M->W control registers,
// E-stage branch/jump resolution and a table of 2-bit direction counters read in D.
module pipe_ctrl_bp #(
  parameter int         BHT_ENTRIES = 16,
  parameter bit         PRED_EN     = 1'b1,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] instrD,
  input  logic [31:0] pcD,
  input  logic [3:0]  nzcvE,
  input  logic        flushE,
  output logic [2:0]  ImmSrcD,
  output logic        predTakenD,
  output logic [4:0]  ALUControlE,
  output logic [1:0]  ALUSrcAE,
  output logic        ALUSrcBE,
  output logic        redirectE,
  output logic [1:0]  PCSrcE,
  output logic        MemWriteM,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW
);

  localparam int IW = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SLT  = 5'b00101,
    ALU_SLTU = 5'b00110,
    ALU_SLL  = 5'b00111,
    ALU_SRL  = 5'b01000,
    ALU_SRA  = 5'b01001
  } alu_ctl_e;

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic [1:0]    result_src;
    logic [4:0]    alu_control;
    logic [1:0]    alu_src_a;
    logic          alu_src_b;
    logic          branch;
    logic          jalr;
    logic [2:0]    funct3;
    logic          pred;
    logic [IW-1:0] idx;
    logic          valid;
  } ctrl_e_t;

  logic [6:0]    op;
  logic [2:0]    funct3D;
  logic          f7b5;
  logic          branchD, jalD;
  logic [IW-1:0] idxD;
  logic [1:0]    alu_op;
  ctrl_e_t       ctrl_d, ctrl_e;
  logic [1:0]    ctr [BHT_ENTRIES];

  logic          n_f, z_f, c_f, v_f;
  logic          taken_e, upd_e;

  logic          reg_write_m, mem_write_m, reg_write_w;
  logic [1:0]    result_src_m, result_src_w;

  logic          unused_bits;

  assign op      = instrD[6:0];
  assign funct3D = instrD[14:12];
  assign f7b5    = instrD[30];
  assign branchD = (op == OP_BR);
  assign jalD    = (op == OP_JAL);
  assign idxD    = pcD[IW+1:2];

  assign predTakenD = jalD | (branchD & PRED_EN & ctr[idxD][1]);

  // Decode: main decoder fields, then ALU decoder from alu_op/funct3/funct7[5].
  always_comb begin
    // NOTE: every combinational output is given a default first so no path infers a latch.
    ctrl_d  = '0;
    ImmSrcD = 3'b000;
    alu_op  = 2'b00;
    case (op)
      OP_LOAD:  begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_b = 1'b1; ctrl_d.result_src = 2'b01; end
      OP_STORE: begin ctrl_d.mem_write = 1'b1; ctrl_d.alu_src_b = 1'b1; ImmSrcD = 3'b001; end
      OP_R:     begin ctrl_d.reg_write = 1'b1; alu_op = 2'b10; end
      OP_I:     begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_b = 1'b1; alu_op = 2'b10; end
      OP_BR:    begin ctrl_d.branch = 1'b1; ImmSrcD = 3'b010; alu_op = 2'b01; end
      OP_JAL:   begin ctrl_d.reg_write = 1'b1; ctrl_d.result_src = 2'b10; ImmSrcD = 3'b011; end
      OP_JALR:  begin
        ctrl_d.reg_write = 1'b1; ctrl_d.jalr = 1'b1;
        ctrl_d.alu_src_b = 1'b1; ctrl_d.result_src = 2'b10;
      end
      OP_LUI:   begin
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 1'b1; ImmSrcD = 3'b100;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 1'b1; ImmSrcD = 3'b100;
      end
      default: ;
    endcase

    case (alu_op)
      2'b00:   ctrl_d.alu_control = ALU_ADD;
      2'b01:   ctrl_d.alu_control = ALU_SUB;
      default: begin
        case (funct3D)
          3'b000:  ctrl_d.alu_control = (op[5] & f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl_d.alu_control = ALU_SLL;
          3'b010:  ctrl_d.alu_control = ALU_SLT;
          3'b011:  ctrl_d.alu_control = ALU_SLTU;
          3'b100:  ctrl_d.alu_control = ALU_XOR;
          3'b101:  ctrl_d.alu_control = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl_d.alu_control = ALU_OR;
          default: ctrl_d.alu_control = ALU_AND;
        endcase
      end
    endcase

    ctrl_d.funct3 = funct3D;
    ctrl_d.pred   = predTakenD;
    ctrl_d.idx    = idxD;
    ctrl_d.valid  = 1'b1;
  end

  // A flush or an E-stage redirect turns the incoming instruction into a bubble.
  always_ff @(posedge clk) begin
    if (n_rst || flushE || redirectE) ctrl_e <= '0;
    else                              ctrl_e <= ctrl_d;
  end

  assign {n_f, z_f, c_f, v_f} = nzcvE;

  always_comb begin
    case (ctrl_e.funct3)
      3'b000:  taken_e = z_f;
      3'b001:  taken_e = ~z_f;
      3'b100:  taken_e = n_f ^ v_f;
      3'b101:  taken_e = ~(n_f ^ v_f);
      3'b110:  taken_e = ~c_f;
      3'b111:  taken_e = c_f;
      default: taken_e = 1'b0;
    endcase
  end

  always_comb begin
    redirectE = 1'b0;
    PCSrcE    = 2'b00;
    if (ctrl_e.valid) begin
      if (ctrl_e.jalr) begin
        redirectE = 1'b1;
        PCSrcE    = 2'b10;
      end else if (ctrl_e.branch && taken_e && !ctrl_e.pred) begin
        redirectE = 1'b1;
        PCSrcE    = 2'b01;
      end else if (ctrl_e.branch && !taken_e && ctrl_e.pred) begin
        redirectE = 1'b1;
        PCSrcE    = 2'b11;
      end
    end
  end

  assign upd_e = ctrl_e.valid & ctrl_e.branch & PRED_EN;

  // Counter table lives in flops; reads in D see the pre-edge value, so no bypass.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      // NOTE: the table is flop-based and every entry must hold CTR_INIT right after reset, so each is reset explicitly.
      for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (upd_e) begin
      if (taken_e && ctr[ctrl_e.idx] != 2'b11)
        ctr[ctrl_e.idx] <= ctr[ctrl_e.idx] + 2'd1;
      else if (!taken_e && ctr[ctrl_e.idx] != 2'b00)
        ctr[ctrl_e.idx] <= ctr[ctrl_e.idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
    end else begin
      reg_write_m  <= ctrl_e.reg_write;
      mem_write_m  <= ctrl_e.mem_write;
      result_src_m <= ctrl_e.result_src;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
    end
  end

  assign ALUControlE = ctrl_e.alu_control;
  assign ALUSrcAE    = ctrl_e.alu_src_a;
  assign ALUSrcBE    = ctrl_e.alu_src_b;
  assign MemWriteM   = mem_write_m;
  assign RegWriteM   = reg_write_m;
  assign ResultSrcM  = result_src_m;
  assign RegWriteW   = reg_write_w;
  assign ResultSrcW  = result_src_w;

  assign unused_bits = ^{instrD[31], instrD[29:15], instrD[11:7], pcD[31:IW+2], pcD[1:0]};

endmodule

// File: tb/tb_pipe_ctrl_bp.sv
// Directed bench for pipe_ctrl_bp: reset, predictor learning, mispredict
// recovery, jumps, flush, branch conditions, alias/conflict and static build.
module tb_pipe_ctrl_bp;

  localparam logic [31:0] ILL   = 32'h0000_0000;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] BNE   = 32'h0000_1063;
  localparam logic [31:0] ADD   = 32'h0000_00B3;
  localparam logic [31:0] SUB   = 32'h4000_00B3;
  localparam logic [31:0] LW    = 32'h0000_2083;
  localparam logic [31:0] SW    = 32'h0000_2023;
  localparam logic [31:0] AUIPC = 32'h0000_0097;
  localparam logic [31:0] JAL   = 32'h0000_00EF;
  localparam logic [31:0] JALR  = 32'h0000_00E7;
  localparam logic [3:0]  FZ    = 4'b0100;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] instrD, pcD;
  logic [3:0]  nzcvE;
  logic        flushE;

  logic [2:0] ImmSrcD;
  logic       predTakenD, ALUSrcBE, redirectE, MemWriteM, RegWriteM, RegWriteW;
  logic [4:0] ALUControlE;
  logic [1:0] ALUSrcAE, PCSrcE, ResultSrcM, ResultSrcW;

  logic [2:0] ImmSrcD_s;
  logic       predTakenD_s, ALUSrcBE_s, redirectE_s, MemWriteM_s, RegWriteM_s, RegWriteW_s;
  logic [4:0] ALUControlE_s;
  logic [1:0] ALUSrcAE_s, PCSrcE_s, ResultSrcM_s, ResultSrcW_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_bp dut (
    .clk(clk), .n_rst(n_rst), .instrD(instrD), .pcD(pcD), .nzcvE(nzcvE), .flushE(flushE),
    .ImmSrcD(ImmSrcD), .predTakenD(predTakenD), .ALUControlE(ALUControlE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .redirectE(redirectE), .PCSrcE(PCSrcE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  pipe_ctrl_bp #(.PRED_EN(1'b0)) dut_s (
    .clk(clk), .n_rst(n_rst), .instrD(instrD), .pcD(pcD), .nzcvE(nzcvE), .flushE(flushE),
    .ImmSrcD(ImmSrcD_s), .predTakenD(predTakenD_s), .ALUControlE(ALUControlE_s),
    .ALUSrcAE(ALUSrcAE_s), .ALUSrcBE(ALUSrcBE_s), .redirectE(redirectE_s), .PCSrcE(PCSrcE_s),
    .MemWriteM(MemWriteM_s), .RegWriteM(RegWriteM_s), .ResultSrcM(ResultSrcM_s),
    .RegWriteW(RegWriteW_s), .ResultSrcW(ResultSrcW_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one branch through D and E with the given flags; returns what was observed.
  task automatic run_br(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] flags,
                        output logic pred, output logic redir, output logic [1:0] src);
    instrD = ins;
    pcD    = pc;
    #1 pred = predTakenD;
    tick();
    instrD = ILL;
    nzcvE  = flags;
    #1;
    redir = redirectE;
    src   = PCSrcE;
    tick();
    nzcvE = 4'b0000;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instrD = $urandom;
      pcD    = $urandom;
      nzcvE  = 4'($urandom);
      tick();
    end
    n_checks++; if (RegWriteM !== 1'b0) $display("FAIL reset_regwm: got %b want 0", RegWriteM); else n_pass++;
    n_checks++; if (MemWriteM !== 1'b0) $display("FAIL reset_memwm: got %b want 0", MemWriteM); else n_pass++;
    n_checks++; if (RegWriteW !== 1'b0) $display("FAIL reset_regww: got %b want 0", RegWriteW); else n_pass++;
    n_checks++; if ({ResultSrcM, ResultSrcW} !== 4'b0) $display("FAIL reset_ressrc: got %b want 0000", {ResultSrcM, ResultSrcW}); else n_pass++;
    n_checks++; if ({ALUControlE, ALUSrcAE, ALUSrcBE} !== 8'b0) $display("FAIL reset_alue: got %b want 0", {ALUControlE, ALUSrcAE, ALUSrcBE}); else n_pass++;
    n_checks++; if ({redirectE, PCSrcE} !== 3'b000) $display("FAIL reset_redirect: got %b want 000", {redirectE, PCSrcE}); else n_pass++;
    n_rst  = 1'b0;
    nzcvE  = 4'b0000;
    instrD = BEQ;
    pcD    = 32'h40;
    #1;
    n_checks++; if (predTakenD !== 1'b0) $display("FAIL reset_ctr_init: got %b want 0", predTakenD); else n_pass++;
    n_checks++; if (ImmSrcD !== 3'b010) $display("FAIL immsrc_beq: got %b want 010", ImmSrcD); else n_pass++;
    instrD = ILL;
    tick();
  endtask

  task automatic test_learning();
    logic p, r;
    logic [1:0] s;
    run_br(BEQ, 32'h40, FZ, p, r, s);
    n_checks++; if (p !== 1'b0) $display("FAIL learn1_pred: got %b want 0", p); else n_pass++;
    n_checks++; if ({r, s} !== 3'b101) $display("FAIL learn1_redirect: got %b want 101", {r, s}); else n_pass++;
    run_br(BEQ, 32'h40, FZ, p, r, s);
    n_checks++; if (p !== 1'b1) $display("FAIL learn2_pred: got %b want 1", p); else n_pass++;
    n_checks++; if ({r, s} !== 3'b000) $display("FAIL learn2_redirect: got %b want 000", {r, s}); else n_pass++;
    run_br(BEQ, 32'h40, FZ, p, r, s);
    n_checks++; if ({p, r, s} !== 4'b1000) $display("FAIL learn3: got %b want 1000", {p, r, s}); else n_pass++;
  endtask

  task automatic test_pred_taken_miss();
    logic p, r;
    logic [1:0] s;
    instrD = BNE;
    pcD    = 32'h40;
    #1;
    n_checks++; if (predTakenD !== 1'b1) $display("FAIL miss_pred: got %b want 1", predTakenD); else n_pass++;
    tick();
    instrD = ADD;
    nzcvE  = FZ;
    #1;
    n_checks++; if ({redirectE, PCSrcE} !== 3'b111) $display("FAIL miss_redirect: got %b want 111", {redirectE, PCSrcE}); else n_pass++;
    tick();
    instrD = ILL;
    nzcvE  = 4'b0000;
    n_checks++; if (RegWriteM !== 1'b0) $display("FAIL miss_bne_m: got %b want 0", RegWriteM); else n_pass++;
    tick();
    n_checks++; if (RegWriteM !== 1'b0) $display("FAIL miss_bubble_m: got %b want 0", RegWriteM); else n_pass++;
    // Counter should now be 10: still taken, one not-taken drops it to 01.
    run_br(BEQ, 32'h40, 4'b0000, p, r, s);
    n_checks++; if ({p, r, s} !== 4'b1111) $display("FAIL miss_ctr10: got %b want 1111", {p, r, s}); else n_pass++;
    instrD = BEQ;
    #1;
    n_checks++; if (predTakenD !== 1'b0) $display("FAIL miss_ctr01: got %b want 0", predTakenD); else n_pass++;
    instrD = ILL;
    tick();
  endtask

  task automatic test_jumps();
    logic p, r;
    logic [1:0] s;
    instrD = JAL;
    pcD    = 32'h40;
    #1;
    n_checks++; if ({predTakenD, ImmSrcD} !== 4'b1011) $display("FAIL jal_d: got %b want 1011", {predTakenD, ImmSrcD}); else n_pass++;
    tick();
    instrD = JALR;
    #1;
    n_checks++; if ({redirectE, PCSrcE} !== 3'b000) $display("FAIL jal_e: got %b want 000", {redirectE, PCSrcE}); else n_pass++;
    n_checks++; if (predTakenD !== 1'b0) $display("FAIL jalr_d: got %b want 0", predTakenD); else n_pass++;
    tick();
    instrD = ILL;
    #1;
    n_checks++; if ({RegWriteM, ResultSrcM} !== 3'b110) $display("FAIL jal_m: got %b want 110", {RegWriteM, ResultSrcM}); else n_pass++;
    n_checks++; if ({redirectE, PCSrcE, ALUSrcBE} !== 4'b1101) $display("FAIL jalr_e: got %b want 1101", {redirectE, PCSrcE, ALUSrcBE}); else n_pass++;
    tick();
    run_br(BEQ, 32'h40, 4'b0000, p, r, s);
    n_checks++; if ({p, r} !== 2'b00) $display("FAIL jump_ctr_unchanged: got %b want 00", {p, r}); else n_pass++;
  endtask

  task automatic test_alu_path();
    instrD = ADD; tick();
    n_checks++; if ({ALUControlE, ALUSrcAE, ALUSrcBE} !== 8'b00000_00_0) $display("FAIL add_e: got %b want 00000000", {ALUControlE, ALUSrcAE, ALUSrcBE}); else n_pass++;
    instrD = SUB; tick();
    n_checks++; if (ALUControlE !== 5'b00001) $display("FAIL sub_e: got %b want 00001", ALUControlE); else n_pass++;
    n_checks++; if (RegWriteM !== 1'b1) $display("FAIL add_m: got %b want 1", RegWriteM); else n_pass++;
    instrD = LW; tick();
    n_checks++; if ({ALUControlE, ALUSrcBE} !== 6'b00000_1) $display("FAIL lw_e: got %b want 000001", {ALUControlE, ALUSrcBE}); else n_pass++;
    n_checks++; if ({RegWriteW, ResultSrcW} !== 3'b100) $display("FAIL add_w: got %b want 100", {RegWriteW, ResultSrcW}); else n_pass++;
    instrD = SW; tick();
    n_checks++; if ({RegWriteM, MemWriteM, ResultSrcM} !== 4'b1001) $display("FAIL lw_m: got %b want 1001", {RegWriteM, MemWriteM, ResultSrcM}); else n_pass++;
    instrD = AUIPC; tick();
    n_checks++; if ({ALUSrcAE, ALUSrcBE} !== 3'b011) $display("FAIL auipc_e: got %b want 011", {ALUSrcAE, ALUSrcBE}); else n_pass++;
    n_checks++; if ({RegWriteM, MemWriteM} !== 2'b01) $display("FAIL sw_m: got %b want 01", {RegWriteM, MemWriteM}); else n_pass++;
    n_checks++; if ({RegWriteW, ResultSrcW} !== 3'b101) $display("FAIL lw_w: got %b want 101", {RegWriteW, ResultSrcW}); else n_pass++;
    instrD = ILL; tick(); tick(); tick();
  endtask

  task automatic test_flush();
    instrD = ADD;
    flushE = 1'b1;
    tick();
    flushE = 1'b0;
    instrD = ILL;
    tick();
    n_checks++; if (RegWriteM !== 1'b0) $display("FAIL flush_m: got %b want 0", RegWriteM); else n_pass++;
    tick();
    n_checks++; if (RegWriteW !== 1'b0) $display("FAIL flush_w: got %b want 0", RegWriteW); else n_pass++;
    // Two flushed taken beqs at idx 2 must leave its counter at 01.
    instrD = BEQ;
    pcD    = 32'h08;
    flushE = 1'b1;
    tick();
    nzcvE = FZ;
    #1;
    n_checks++; if (redirectE !== 1'b0) $display("FAIL flush_br_redirect: got %b want 0", redirectE); else n_pass++;
    tick();
    flushE = 1'b0;
    #1;
    n_checks++; if (predTakenD !== 1'b0) $display("FAIL flush_ctr: got %b want 0", predTakenD); else n_pass++;
    instrD = ILL;
    nzcvE  = 4'b0000;
    tick();
  endtask

  task automatic test_conditions();
    logic [2:0]  f3v [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b100};
    logic [3:0]  flv [8] = '{4'b0100, 4'b0100, 4'b1000, 4'b1001, 4'b0010, 4'b0010, 4'b0100, 4'b1001};
    logic        tkv [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic p, r;
    logic [1:0] s;
    for (int i = 0; i < 8; i++) begin
      run_br(BEQ | {17'b0, f3v[i], 12'b0}, 32'h10 + 32'(4 * i), flv[i], p, r, s);
      n_checks++;
      if ({p, r, s} !== {1'b0, tkv[i], tkv[i] ? 2'b01 : 2'b00})
        $display("FAIL cond_%0d: f3=%b flags=%b got %b want %b", i, f3v[i], flv[i], {p, r, s},
                 {1'b0, tkv[i], tkv[i] ? 2'b01 : 2'b00});
      else n_pass++;
    end
  endtask

  task automatic test_conflict_alias();
    instrD = BEQ;
    pcD    = 32'h0C;
    tick();
    pcD   = 32'h4C;
    nzcvE = FZ;
    #1;
    n_checks++; if (predTakenD !== 1'b0) $display("FAIL conflict_old: got %b want 0", predTakenD); else n_pass++;
    n_checks++; if ({redirectE, PCSrcE} !== 3'b101) $display("FAIL conflict_redirect: got %b want 101", {redirectE, PCSrcE}); else n_pass++;
    tick();
    #1;
    n_checks++; if (predTakenD !== 1'b1) $display("FAIL alias_shared: got %b want 1", predTakenD); else n_pass++;
    tick();
    instrD = ILL;
    #1;
    n_checks++; if (redirectE !== 1'b0) $display("FAIL alias_correct: got %b want 0", redirectE); else n_pass++;
    tick();
    nzcvE = 4'b0000;
  endtask

  task automatic test_mid_reset();
    instrD = ADD;
    tick();
    n_rst = 1'b1;
    tick();
    n_rst  = 1'b0;
    instrD = BEQ;
    pcD    = 32'h0C;
    #1;
    n_checks++; if ({RegWriteM, RegWriteW} !== 2'b00) $display("FAIL midrst_mw: got %b want 00", {RegWriteM, RegWriteW}); else n_pass++;
    n_checks++; if (predTakenD !== 1'b0) $display("FAIL midrst_ctr: got %b want 0", predTakenD); else n_pass++;
    instrD = ILL;
    tick();
  endtask

  task automatic test_static_build();
    for (int i = 0; i < 4; i++) begin
      instrD = BEQ;
      pcD    = 32'h40;
      #1;
      n_checks++; if (predTakenD_s !== 1'b0) $display("FAIL static_pred_%0d: got %b want 0", i, predTakenD_s); else n_pass++;
      tick();
      instrD = ILL;
      nzcvE  = FZ;
      #1;
      n_checks++; if ({redirectE_s, PCSrcE_s} !== 3'b101) $display("FAIL static_redirect_%0d: got %b want 101", i, {redirectE_s, PCSrcE_s}); else n_pass++;
      tick();
      nzcvE = 4'b0000;
    end
    instrD = JAL;
    #1;
    n_checks++; if (predTakenD_s !== 1'b1) $display("FAIL static_jal: got %b want 1", predTakenD_s); else n_pass++;
    instrD = ILL;
    tick();
  endtask

  initial begin
    n_rst  = 1'b1;
    instrD = ILL;
    pcD    = 32'h0;
    nzcvE  = 4'b0000;
    flushE = 1'b0;
    test_reset();
    test_learning();
    test_pred_taken_miss();
    test_jumps();
    test_alu_path();
    test_flush();
    test_conditions();
    test_conflict_alias();
    test_mid_reset();
    test_static_build();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
